winograd_acc_pe: RTL

WINOGRAD_ACC_PE -- requirements
Module: winograd_acc_pe

---
 rtl/winograd_acc_pe.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/winograd_acc_pe.sv
// winograd_acc_pe
//   Systolic processing element for a Winograd F(4x4,3x3) convolution array.
//   Each cycle it registers a transformed data tile from the top neighbour and a
//   transformed weight tile from the left neighbour, and forwards both downstream.
//   The registered pair is multiplied elementwise. In mode 0 the product is
//   output-transformed (AT*P*A). In mode 1 it is used as is. The result is
//   accumulated over cfg_num_ch_i input channels.
//   A finished tile goes to a one-entry output buffer with a valid/ready handshake.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   cfg_num_ch_i                     input channels per output tile (0 acts as 1)
//   data_tile_i / data_valid_i       6x6 data tile (element k at [k*DATA_W +: DATA_W],
//   data_x_index_i, data_y_index_i   k = row*6+col) and its origin index
//   weight_tile_i / weight_valid_i   6x6 weight tile, output-channel tag and mode
//   weight_od_i, weight_mode_i       (0 = Winograd F(4x4,3x3), 1 = 1x1 elementwise)
//   data_*_o, weight_*_o             registered forward path to bottom/right neighbours
//   stall_i / stall_o                downstream holding / this PE holding
//   result_tile_o ... result_mode_o  buffered result tile and its tags
//   result_valid_o / result_ready_i  result handshake
//
// Configuration macro
//   PE_SAT_EN  defined: buffered elements saturate to the signed OUT_W range;
//              undefined: elements are truncated to their low OUT_W bits.

module winograd_acc_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 9,
    parameter int OD_W   = 8,
    parameter int CH_W   = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CH_W-1:0]       cfg_num_ch_i,
    input  logic [36*DATA_W-1:0]  data_tile_i,
    input  logic                  data_valid_i,
    input  logic [IDX_W-1:0]      data_x_index_i,
    input  logic [IDX_W-1:0]      data_y_index_i,
    input  logic [36*DATA_W-1:0]  weight_tile_i,
    input  logic                  weight_valid_i,
    input  logic [OD_W-1:0]       weight_od_i,
    input  logic                  weight_mode_i,
    output logic [36*DATA_W-1:0]  data_tile_o,
    output logic                  data_valid_o,
    output logic [IDX_W-1:0]      data_x_index_o,
    output logic [IDX_W-1:0]      data_y_index_o,
    output logic [36*DATA_W-1:0]  weight_tile_o,
    output logic                  weight_valid_o,
    output logic [OD_W-1:0]       weight_od_o,
    output logic                  weight_mode_o,
    input  logic                  stall_i,
    output logic                  stall_o,
    output logic [36*OUT_W-1:0]   result_tile_o,
    output logic [OD_W-1:0]       result_od_o,
    output logic [IDX_W-1:0]      result_x_o,
    output logic [IDX_W-1:0]      result_y_o,
    output logic                  result_mode_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i
);

    localparam int NE = 36;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t                 state, state_nxt;
    logic                       hold, fire, is_last, last_fire, first;
    logic [CH_W-1:0]            num_ch, ch_cnt;
    logic signed [2*DATA_W-1:0] prod  [NE];
    logic signed [ACC_W-1:0]    p_ext [NE];
    logic signed [ACC_W-1:0]    mid   [24];
    logic signed [ACC_W-1:0]    t_elem [NE];
    logic signed [ACC_W-1:0]    acc    [NE];
    logic signed [ACC_W-1:0]    acc_nxt [NE];
    logic [36*OUT_W-1:0]        buf_nxt;
    logic [OD_W-1:0]            acc_od, od_nxt;
    logic [IDX_W-1:0]           acc_x, acc_y, x_nxt, y_nxt;
    logic                       acc_mode, mode_nxt;

    // One row of AT applied to a 6-element vector, using shifts and adds only.
    function automatic logic signed [ACC_W-1:0] at_row(
        input logic [1:0] r,
        input logic signed [ACC_W-1:0] v0, v1, v2, v3, v4, v5);
        case (r)
            2'd0:    return v0 + v1 + v2 + v3 + v4;
            2'd1:    return (v1 - v2) + ((v3 - v4) <<< 1);
            2'd2:    return (v1 + v2) + ((v3 + v4) <<< 2);
            default: return (v1 - v2) + ((v3 - v4) <<< 3) + v5;
        endcase
    endfunction

    // Narrow an accumulator element to the result width.
    function automatic logic [OUT_W-1:0] to_out(input logic signed [ACC_W-1:0] v);
`ifdef PE_SAT_EN
        // The value fits when all bits above the result sign bit copy the sign.
        if (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}})
            return v[OUT_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b0, {(OUT_W-1){1'b1}}};
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    // Control: a zero channel count acts as one. A counter at or past the
    // last channel (cfg lowered mid-tile) is treated as the last channel.
    always_comb begin
        num_ch    = (cfg_num_ch_i == '0) ? CH_W'(1) : cfg_num_ch_i;
        is_last   = (ch_cnt >= (num_ch - CH_W'(1)));
        first     = (ch_cnt == '0);
        stall_o   = (state == FULL) & ~result_ready_i & data_valid_o & weight_valid_o & is_last;
        hold      = stall_o | stall_i;
        fire      = data_valid_o & weight_valid_o & ~hold;
        last_fire = fire & is_last;
    end

    // Elementwise product and tile transform. The first pass applies AT down the
    // columns (AT*P). The second applies AT across the rows, which multiplies by A.
    always_comb begin
        for (int k = 0; k < NE; k++) begin
            prod[k]  = $signed(data_tile_o[k*DATA_W +: DATA_W]) *
                       $signed(weight_tile_o[k*DATA_W +: DATA_W]);
            p_ext[k] = ACC_W'(prod[k]);
        end
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 6; j++)
                mid[r*6+j] = at_row(2'(r), p_ext[j], p_ext[6+j], p_ext[12+j],
                                    p_ext[18+j], p_ext[24+j], p_ext[30+j]);
        for (int k = 0; k < NE; k++)
            t_elem[k] = '0;
        if (weight_mode_o) begin
            for (int k = 0; k < NE; k++)
                t_elem[k] = p_ext[k];
        end else begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t_elem[r*6+c] = at_row(2'(c), mid[r*6], mid[r*6+1], mid[r*6+2],
                                           mid[r*6+3], mid[r*6+4], mid[r*6+5]);
        end
    end

    // Next accumulator value and tags. The first channel restarts the sum and
    // takes its tags; later channels keep the tags latched by the first one.
    always_comb begin
        for (int k = 0; k < NE; k++) begin
            acc_nxt[k] = first ? t_elem[k] : acc[k] + t_elem[k];
            buf_nxt[k*OUT_W +: OUT_W] = to_out(acc_nxt[k]);
        end
        od_nxt   = first ? weight_od_o    : acc_od;
        x_nxt    = first ? data_x_index_o : acc_x;
        y_nxt    = first ? data_y_index_o : acc_y;
        mode_nxt = first ? weight_mode_o  : acc_mode;
    end

    // Forward path. A cleared valid zeroes the whole group, so neighbours never
    // see stale tiles. Everything freezes while this PE or downstream holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_tile_o    <= '0;
            data_valid_o   <= 1'b0;
            data_x_index_o <= '0;
            data_y_index_o <= '0;
            weight_tile_o  <= '0;
            weight_valid_o <= 1'b0;
            weight_od_o    <= '0;
            weight_mode_o  <= 1'b0;
        end else if (!hold) begin
            data_valid_o   <= data_valid_i;
            data_tile_o    <= data_valid_i ? data_tile_i : '0;
            data_x_index_o <= data_valid_i ? data_x_index_i : '0;
            data_y_index_o <= data_valid_i ? data_y_index_i : '0;
            weight_valid_o <= weight_valid_i;
            weight_tile_o  <= weight_valid_i ? weight_tile_i : '0;
            weight_od_o    <= weight_valid_i ? weight_od_i : '0;
            weight_mode_o  <= weight_valid_i ? weight_mode_i : 1'b0;
        end
    end

    // Accumulator and channel counter advance on every fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NE; k++)
                acc[k] <= '0;
            ch_cnt   <= '0;
            acc_od   <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
            acc_mode <= 1'b0;
        end else if (fire) begin
            for (int k = 0; k < NE; k++)
                acc[k] <= acc_nxt[k];
            ch_cnt   <= is_last ? '0 : ch_cnt + CH_W'(1);
            acc_od   <= od_nxt;
            acc_x    <= x_nxt;
            acc_y    <= y_nxt;
            acc_mode <= mode_nxt;
        end
    end

    // Output buffer. It loads on every last fire. The stall guarantees a full
    // buffer is only overwritten in the cycle its content is being consumed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_tile_o <= '0;
            result_od_o   <= '0;
            result_x_o    <= '0;
            result_y_o    <= '0;
            result_mode_o <= 1'b0;
        end else if (last_fire) begin
            result_tile_o <= buf_nxt;
            result_od_o   <= od_nxt;
            result_x_o    <= x_nxt;
            result_y_o    <= y_nxt;
            result_mode_o <= mode_nxt;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Buffer next state. A new result replacing a consumed one keeps it FULL.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (last_fire) state_nxt = FULL;
            FULL:    if (!last_fire && result_ready_i) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
        result_valid_o = (state == FULL);
    end

endmodule
